// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and delay helpers for the LCD controller.
package lcd_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT_ISSUE,
      IDLE,
      SETUP,
      EN_HIGH,
      HOLD,
      WAIT
   } lcd_state_e;

   localparam logic [7:0] CLEAR      = 8'h01;
   localparam logic [7:0] HOME       = 8'h02;
   localparam logic [7:0] ENTRY_INC  = 8'h06;
   localparam logic [7:0] DISP_ON    = 8'h0C;
   localparam logic [7:0] DISP_OFF   = 8'h08;
   localparam logic [7:0] FSET_8B_2L = 8'h38;
   localparam logic [7:0] FSET_8B_1L = 8'h30;
   localparam logic [7:0] WAKE       = 8'h30;

   // Extra-long waits after the first two wake-up writes of the init sequence
   localparam int unsigned STEP0_WAIT_US = 4100;
   localparam int unsigned STEP1_WAIT_US = 100;

   localparam int unsigned INIT_STEPS = 8;

   // ceil(us * clk_hz / 1e6), evaluated in 64-bit to avoid overflow
   function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned clk_hz);
      longint unsigned prod;
      prod = longint'(us) * longint'(clk_hz);
      return 32'((prod + 64'd999999) / 64'd1000000);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Clear and home (and 0x03, which decodes as home) need the long execution time
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return (rs == 1'b0) && (data == 8'h01 || data == 8'h02 || data == 8'h03);
   endfunction

endpackage

// File: rtl/lcd_delay.sv
// Loadable down-counter; done is high in the cycle the count sits at zero.
module lcd_delay #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         done,
   output logic         busy
);

   logic [W-1:0] count_q;
   logic         active_q;

   // Count down from the loaded value; a load always wins and restarts the count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         active_q <= 1'b0;
      end else if (load) begin
         count_q  <= value;
         active_q <= 1'b1;
      end else if (active_q) begin
         if (count_q == '0) begin
            active_q <= 1'b0;
         end else begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign done = active_q && (count_q == '0);
   assign busy = active_q;

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style 8-bit write-only LCD controller: power-on init sequence, then
// single-byte command/data writes with E strobe timing and execution waits.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 50000000,
   parameter int unsigned INIT_WAIT_US = 15000,
   parameter int unsigned CMD_WAIT_US  = 40,
   parameter int unsigned CLR_WAIT_US  = 1640,
   parameter int unsigned EN_CYC       = 12,
   parameter int unsigned TWO_LINE     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic       wr_rs,
   input  logic [7:0] wr_data,
   output logic       init_done,
   output logic       data_out_on,
   output logic       data_out_en,
   output logic       data_out_rs,
   output logic       data_out_rw,
   output logic [7:0] data_out
);

   localparam int unsigned INIT_CYC  = us_to_cyc(INIT_WAIT_US, CLK_HZ);
   localparam int unsigned CMD_CYC   = us_to_cyc(CMD_WAIT_US, CLK_HZ);
   localparam int unsigned CLR_CYC   = us_to_cyc(CLR_WAIT_US, CLK_HZ);
   localparam int unsigned STEP0_CYC = us_to_cyc(STEP0_WAIT_US, CLK_HZ);
   localparam int unsigned STEP1_CYC = us_to_cyc(STEP1_WAIT_US, CLK_HZ);
   localparam int unsigned MAX_CYC   = max_u(max_u(max_u(INIT_CYC, CMD_CYC),
                                                   max_u(CLR_CYC, STEP0_CYC)),
                                             max_u(STEP1_CYC, EN_CYC));
   localparam int unsigned TW        = $clog2(MAX_CYC) + 1;

   // The power-on wait spans INIT_CYC cycles counting the PWR_WAIT load cycle,
   // the done cycle and the INIT_ISSUE cycle, so the counter gets INIT_CYC-3.
   localparam logic [TW-1:0] PWR_LOAD = TW'((INIT_CYC > 32'd3) ? INIT_CYC - 32'd3 : 32'd0);
   // Counter loads are length-1 so the state lasts exactly the requested cycles
   localparam logic [TW-1:0] EN_M1    = TW'((EN_CYC > 32'd0) ? EN_CYC - 32'd1 : 32'd0);
   localparam logic [TW-1:0] CMD_M1   = TW'((CMD_CYC > 32'd0) ? CMD_CYC - 32'd1 : 32'd0);
   localparam logic [TW-1:0] CLR_M1   = TW'((CLR_CYC > 32'd0) ? CLR_CYC - 32'd1 : 32'd0);
   localparam logic [TW-1:0] S0_M1    = TW'((STEP0_CYC > 32'd0) ? STEP0_CYC - 32'd1 : 32'd0);
   localparam logic [TW-1:0] S1_M1    = TW'((STEP1_CYC > 32'd0) ? STEP1_CYC - 32'd1 : 32'd0);

   function automatic logic [7:0] init_byte(input logic [2:0] step);
      logic [7:0] b;
      case (step)
         3'd0, 3'd1, 3'd2: b = WAKE;
         3'd3:             b = (TWO_LINE != 0) ? FSET_8B_2L : FSET_8B_1L;
         3'd4:             b = DISP_OFF;
         3'd5:             b = CLEAR;
         3'd6:             b = ENTRY_INC;
         default:          b = DISP_ON;
      endcase
      return b;
   endfunction

   function automatic logic [TW-1:0] cmd_wait(input logic rs, input logic [7:0] data);
      return is_long_cmd(rs, data) ? CLR_M1 : CMD_M1;
   endfunction

   lcd_state_e    state_q, state_d;
   logic [2:0]    step_q, step_d;
   logic          init_done_q, init_done_d;
   logic          rs_q, rs_d;
   logic [7:0]    data_q, data_d;
   logic [TW-1:0] wait_q, wait_d;
   logic          tmr_load;
   logic [TW-1:0] tmr_value;
   logic          tmr_done;
   logic          tmr_busy;
   logic [7:0]    rom_byte;

   assign rom_byte = init_byte(step_q);

   lcd_delay #(
      .W (TW)
   ) u_delay (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_value),
      .done  (tmr_done),
      .busy  (tmr_busy)
   );

   // State, init progress and the captured bus byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= PWR_WAIT;
         step_q      <= 3'd0;
         init_done_q <= 1'b0;
         rs_q        <= 1'b0;
         data_q      <= 8'h00;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         init_done_q <= init_done_d;
         rs_q        <= rs_d;
         data_q      <= data_d;
         wait_q      <= wait_d;
      end
   end

   // Next-state logic; the shared timer paces power-on wait, E width and exec wait
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      init_done_d = init_done_q;
      rs_d        = rs_q;
      data_d      = data_q;
      wait_d      = wait_q;
      tmr_load    = 1'b0;
      tmr_value   = '0;
      case (state_q)
         PWR_WAIT: begin
            if (!tmr_busy) begin
               tmr_load  = 1'b1;
               tmr_value = PWR_LOAD;
            end
            if (tmr_done) begin
               state_d = INIT_ISSUE;
            end
         end
         INIT_ISSUE: begin
            rs_d   = 1'b0;
            data_d = rom_byte;
            if (step_q == 3'd0) begin
               wait_d = S0_M1;
            end else if (step_q == 3'd1) begin
               wait_d = S1_M1;
            end else begin
               wait_d = cmd_wait(1'b0, rom_byte);
            end
            state_d = SETUP;
         end
         IDLE: begin
            if (wr_valid && wr_ready) begin
               rs_d    = wr_rs;
               data_d  = wr_data;
               wait_d  = cmd_wait(wr_rs, wr_data);
               state_d = SETUP;
            end
         end
         SETUP: begin
            tmr_load  = 1'b1;
            tmr_value = EN_M1;
            state_d   = EN_HIGH;
         end
         EN_HIGH: begin
            if (tmr_done) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            tmr_load  = 1'b1;
            tmr_value = wait_q;
            state_d   = WAIT;
         end
         WAIT: begin
            if (tmr_done) begin
               if (init_done_q) begin
                  state_d = IDLE;
               end else if (step_q == 3'(INIT_STEPS - 1)) begin
                  state_d     = IDLE;
                  init_done_d = 1'b1;
               end else begin
                  step_d  = step_q + 3'd1;
                  state_d = INIT_ISSUE;
               end
            end
         end
         default: begin
            state_d = PWR_WAIT;
         end
      endcase
   end

   // E follows state directly so an asynchronous reset drops it at once
   assign data_out_en = (state_q == EN_HIGH);
   assign data_out_rs = rs_q;
   assign data_out    = data_q;
   assign data_out_rw = 1'b0;
   assign data_out_on = ~rst;
   assign wr_ready    = (state_q == IDLE) && init_done_q;
   assign init_done   = init_done_q;

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 The parameter CLK_HZ SHALL default to 50000000 and give the clk frequency in Hz.
REQ-002 The parameter INIT_WAIT_US SHALL default to 15000 and give the power-on wait before the first command.
REQ-003 The parameter CMD_WAIT_US SHALL default to 40 and give the post-write wait for ordinary commands and data (legal range 1 or more).
REQ-004 The parameter CLR_WAIT_US SHALL default to 1640 and give the post-write wait for clear/home commands.
REQ-005 The parameter EN_CYC SHALL default to 12 and give the enable-high width in clk cycles (legal range 1 or more).
REQ-006 The parameter TWO_LINE SHALL default to 1; 1 selects 2-line 5x8 mode, 0 selects 1-line mode.
REQ-007 The port clk SHALL be an input, 1 bit wide: the single clock.
REQ-008 The port rst SHALL be an input, 1 bit wide: the reset, asynchronous and active-high.
REQ-009 The port wr_valid SHALL be an input, 1 bit wide: the write request.
REQ-010 The port wr_ready SHALL be an output, 1 bit wide: the controller can accept a write.
REQ-011 The port wr_rs SHALL be an input, 1 bit wide: 0 for command, 1 for character data.
REQ-012 The port wr_data SHALL be an input, 8 bits wide: the byte to write.
REQ-013 The port init_done SHALL be an output, 1 bit wide: the init sequence is complete.
REQ-014 The port data_out_on SHALL be an output, 1 bit wide: panel power.
REQ-015 The port data_out_en SHALL be an output, 1 bit wide: the LCD E strobe.
REQ-016 The port data_out_rs SHALL be an output, 1 bit wide: the LCD RS.
REQ-017 The port data_out_rw SHALL be an output, 1 bit wide: the LCD R/W, tied to 0 (write-only).
REQ-018 The port data_out SHALL be an output, 8 bits wide: the LCD DB[7:0].

Function
REQ-019 Delays SHALL be converted to cycles at elaboration as ceil(us*CLK_HZ/1e6), and the timer width SHALL be $clog2 of the largest count plus 1.
REQ-020 The FSM SHALL have exactly these states: PWR_WAIT, INIT_ISSUE, IDLE, SETUP, EN_HIGH, HOLD, WAIT.
- Transition PWR_WAIT -> INIT_ISSUE occurs after the INIT_WAIT_US count.
- The init ROM SHALL hold 8 steps, issued in order: 0x30, 0x30, 0x30, function set (0x38 if TWO_LINE else 0x30), 0x08, 0x01, 0x06, 0x0C.
- Waits after the init steps SHALL be: step 0 = 4100 us; step 1 = 100 us; other steps per REQ-023.
REQ-021 Each write, init or user, SHALL follow this cycle-level sequence:
- SETUP: 1 cycle; RS and data driven, en=0.
- EN_HIGH: exactly EN_CYC cycles with en=1.
- HOLD: 1 cycle; en=0, RS and data unchanged.
- WAIT: the selected delay.
REQ-022 After WAIT, the FSM SHALL go to INIT_ISSUE (next step) while init is incomplete, otherwise to IDLE.
REQ-023 The delay SHALL be CLR_WAIT_US when rs=0 and data is 0x01, 0x02 or 0x03; otherwise it SHALL be CMD_WAIT_US.
REQ-024 init_done SHALL rise on the cycle the FSM first enters IDLE after step 7 and SHALL stay high until reset.
REQ-025 wr_ready SHALL be 1 only in IDLE with init_done=1, and it is combinational from state.
REQ-026 A write SHALL be accepted when wr_valid && wr_ready.
- wr_rs and wr_data are captured on that edge, and the FSM moves to SETUP the next cycle.
- Latency from accept to the first en=1 cycle SHALL be 2 clocks.
REQ-027 wr_valid asserted while wr_ready=0 SHALL be ignored, with no capture and no queue; the requester holds it until ready.
REQ-028 data_out and data_out_rs SHALL hold their last value in IDLE and WAIT.
REQ-029 data_out_rw SHALL be 0 at all times, and data_out_on SHALL be 1 at all times outside reset.

Reset
REQ-030 While rst=1, the outputs SHALL be: en=0, rs=0, rw=0, data_out=0x00, on=0, wr_ready=0, init_done=0; state=PWR_WAIT; timer and step index cleared.
REQ-031 Reset asserted mid-write SHALL drop en immediately (asynchronously), and on release the full init sequence SHALL restart from PWR_WAIT.

Structure
REQ-032 The package lcd_pkg SHALL hold the state enum, the command constants (CLEAR, HOME, ENTRY_INC, DISP_ON, DISP_OFF, FSET_8B_2L, FSET_8B_1L, WAKE) and the function us_to_cyc.
REQ-033 There SHALL be one sub-module, lcd_delay: a down-counter with load/value inputs and a done output.
- done SHALL be high the cycle the count reaches 0.
- A load of 0 SHALL produce done on the next cycle.

Verification
(All scenarios use CLK_HZ=1000000, INIT_WAIT_US=20, CMD_WAIT_US=3, CLR_WAIT_US=10, EN_CYC=2, TWO_LINE=1.)
REQ-034 Init: release rst, then:
- The bus SHALL show exactly 8 en pulses, each 2 cycles wide, carrying data 30,30,30,38,08,01,06,0C with rs=0.
- The first pulse SHALL start 21 cycles after release.
- The gap after 0x01 SHALL be at least 10 cycles.
- init_done SHALL rise after 0x0C's wait.
REQ-035 Data write: with ready=1, drive valid, rs=1, data=0x41 for one cycle:
- SETUP, then en high cycles 2-3 with rs=1 and data=0x41.
- wr_ready SHALL be 0 for 1+2+1+3 cycles, then 1.
REQ-036 Clear timing: write rs=0, data=0x01 -> wr_ready SHALL stay low for 1+2+1+10 cycles; repeating with data=0x80 SHALL give 1+2+1+3.
REQ-037 Backpressure: hold valid with data=0x42 from mid-WAIT of a prior write -> no capture until ready, then exactly one pulse with 0x42 and no duplicate.
REQ-038 Reset mid-pulse: assert rst during EN_HIGH -> en=0 the same cycle; after release, init SHALL restart (first pulse 0x30 after 21 cycles) and init_done=0 until it completes.
REQ-039 TWO_LINE=0: the fourth init byte SHALL be 0x30.
